// File: rtl/lmac_fifo_pkg.sv
// Shared types and helpers for the LMAC transmit FIFO: line-rate modes and read pacing divisors.
package lmac_fifo_pkg;

  localparam int unsigned PACE_W = 4;

  typedef enum logic [1:0] {
    MODE_10G  = 2'd0,
    MODE_5G   = 2'd1,
    MODE_2P5G = 2'd2,
    MODE_1G   = 2'd3
  } lmac_mode_e;

  // Cycles between consecutive reads for each line rate, relative to the 10G rate.
  function automatic logic [PACE_W-1:0] pace_div(input lmac_mode_e m);
    logic [PACE_W-1:0] d;
    case (m)
      MODE_10G:  d = 4'd1;
      MODE_5G:   d = 4'd2;
      MODE_2P5G: d = 4'd4;
      MODE_1G:   d = 4'd10;
      default:   d = 4'd1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lmac_fifo_mem.sv
// Simple dual-port storage for the TX FIFO: synchronous write, registered read.
module lmac_fifo_mem #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [DATA_W-1:0]          rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array carries no reset; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/lmac_txfifo_paced.sv
// LMAC TX FIFO: buffers MAC words for the PCS encoder, drains at the active line rate, flags errors.
module lmac_txfifo_paced
  import lmac_fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         rd_req,
  input  logic [1:0]                   mode,
  input  logic                         clr_err,
  output logic                         rd_valid,
  output logic [DATA_W-1:0]            rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         almost_full,
  output logic                         empty,
  output logic                         almost_empty,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [PACE_W-1:0] pace_cnt;
  logic [1:0]        mode_q;

  logic              wr_fire;
  logic              rd_fire;
  logic              pace_ok;
  logic              mode_chg;
  lmac_mode_e        mode_e;
  logic [CW-1:0]     count_next;
  logic [PACE_W-1:0] pace_next;
  logic              overflow_next;
  logic              underflow_next;

  // Acceptance, occupancy and pacing decisions for this cycle.
  always_comb begin
    mode_e         = lmac_mode_e'(mode);
    mode_chg       = (mode != mode_q);
    pace_ok        = (pace_cnt == PACE_W'(0));
    wr_fire        = wr_en & ~full;
    rd_fire        = rd_req & ~empty & pace_ok;
    count_next     = count;
    pace_next      = pace_cnt;
    overflow_next  = overflow & ~clr_err;
    underflow_next = underflow & ~clr_err;

    case ({wr_fire, rd_fire})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase

    // A rate switch restarts pacing so the new rate takes effect immediately.
    if (mode_chg) begin
      pace_next = '0;
    end else if (rd_fire) begin
      pace_next = pace_div(mode_e) - PACE_W'(1);
    end else if (pace_cnt != PACE_W'(0)) begin
      pace_next = pace_cnt - PACE_W'(1);
    end

    // Error set takes priority over a same-cycle clear.
    if (wr_en & full) begin
      overflow_next = 1'b1;
    end
    if (rd_req & empty) begin
      underflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    mode_q <= mode;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pace_cnt <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      pace_cnt <= pace_next;
      rd_valid <= rd_fire;
    end
  end

  // Flags follow the post-edge occupancy so they never lag the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      count        <= count_next;
      full         <= (count_next == CW'(DEPTH));
      almost_full  <= (count_next >= CW'(AF_LEVEL));
      empty        <= (count_next == CW'(0));
      almost_empty <= (count_next <= CW'(AE_LEVEL));
      overflow     <= overflow_next;
      underflow    <= underflow_next;
    end
  end

  lmac_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (rd_fire),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_lmac_txfifo_paced.sv
// Self-checking bench for lmac_txfifo_paced: directed table, corner sequences, randomized model check.
module tb_lmac_txfifo_paced;

  localparam int unsigned DW = 64;
  localparam int unsigned DP = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_req;
  logic [1:0]    mode;
  logic          clr_err;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [4:0]    count;
  logic          full, almost_full, empty, almost_empty, overflow, underflow;

  always #5 clk = ~clk;

  lmac_txfifo_paced #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_req(rd_req),
    .mode(mode), .clr_err(clr_err), .rd_valid(rd_valid), .rd_data(rd_data),
    .count(count), .full(full), .almost_full(almost_full), .empty(empty),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of words plus the earliest cycle a read may fire.
  logic [DW-1:0] mq[$];
  bit            m_ov, m_un, m_rv;
  logic [DW-1:0] m_rd;
  int            cyc = 0;
  int            next_ok = 0;
  logic [1:0]    prev_mode = 2'd0;

  typedef struct {
    bit          r;
    bit          w;
    logic [63:0] d;
    bit          rr;
    bit          ce;
    int          e_count;
    bit          e_rv;
    logic [63:0] e_rd;
    bit          e_un;
  } vec_t;

  vec_t vecs[9];

  function automatic int div_of(input logic [1:0] m);
    case (m)
      2'd0: return 1;
      2'd1: return 2;
      2'd2: return 4;
      default: return 10;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare every output after the edge.
  task automatic cycle(input bit r, input bit w, input logic [63:0] d, input bit rr,
                       input logic [1:0] md, input bit ce);
    bit m_empty, m_full, rf;
    rst = r; wr_en = w; wr_data = d; rd_req = rr; mode = md; clr_err = ce;
    if (r) begin
      mq.delete();
      m_ov = 0; m_un = 0; m_rv = 0; m_rd = '0;
      next_ok = cyc + 1;
    end else begin
      m_empty = (mq.size() == 0);
      m_full  = (mq.size() == DP);
      rf = rr && !m_empty && (cyc >= next_ok);
      m_rv = rf;
      if (rf) m_rd = mq.pop_front();
      if (w && !m_full) mq.push_back(d);
      m_ov = (w && m_full) ? 1'b1 : (m_ov && !ce);
      m_un = (rr && m_empty) ? 1'b1 : (m_un && !ce);
      if (md != prev_mode) next_ok = cyc + 1;
      else if (rf) next_ok = cyc + div_of(md);
    end
    prev_mode = md;
    cyc++;
    @(posedge clk);
    #1;
    chk("m_count", 64'(count), 64'(mq.size()));
    chk("m_full", 64'(full), 64'(mq.size() == DP));
    chk("m_almost_full", 64'(almost_full), 64'(mq.size() >= DP - 2));
    chk("m_empty", 64'(empty), 64'(mq.size() == 0));
    chk("m_almost_empty", 64'(almost_empty), 64'(mq.size() <= 1));
    chk("m_rd_valid", 64'(rd_valid), 64'(m_rv));
    chk("m_rd_data", rd_data, m_rd);
    chk("m_overflow", 64'(overflow), 64'(m_ov));
    chk("m_underflow", 64'(underflow), 64'(m_un));
  endtask

  task automatic idle(input logic [1:0] md);
    cycle(0, 0, '0, 0, md, 0);
  endtask

  initial begin
    int pulses[$];
    int sw;
    logic [1:0] md;
    rst = 1'b1; wr_en = 0; wr_data = '0; rd_req = 0; mode = 2'd0; clr_err = 0;

    // Directed table at 10G: reset, underflow, clear, read/write overlap, hold, set-beats-clear.
    vecs[0] = '{1, 0, 64'h0,  0, 0, 0, 0, 64'h0,  0};
    vecs[1] = '{0, 0, 64'h0,  1, 0, 0, 0, 64'h0,  1};
    vecs[2] = '{0, 0, 64'h0,  0, 1, 0, 0, 64'h0,  0};
    vecs[3] = '{0, 1, 64'h11, 0, 0, 1, 0, 64'h0,  0};
    vecs[4] = '{0, 1, 64'h22, 1, 0, 1, 1, 64'h11, 0};
    vecs[5] = '{0, 0, 64'h0,  1, 0, 0, 1, 64'h22, 0};
    vecs[6] = '{0, 0, 64'h0,  0, 0, 0, 0, 64'h22, 0};
    vecs[7] = '{0, 0, 64'h0,  1, 1, 0, 0, 64'h22, 1};
    vecs[8] = '{0, 0, 64'h0,  0, 1, 0, 0, 64'h22, 0};
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].r, vecs[i].w, vecs[i].d, vecs[i].rr, 2'd0, vecs[i].ce);
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].e_count));
      chk($sformatf("vec%0d_rd_valid", i), 64'(rd_valid), 64'(vecs[i].e_rv));
      chk($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].e_rd);
      chk($sformatf("vec%0d_underflow", i), 64'(underflow), 64'(vecs[i].e_un));
      if (i == 0) begin
        chk("reset_empty", 64'(empty), 64'd1);
        chk("reset_almost_empty", 64'(almost_empty), 64'd1);
        chk("reset_full", 64'(full), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
      end
    end

    // Fill and drain at 10G.
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, 64'(i), 0, 2'd0, 0);
      if (i == 12) chk("fill_af_at13", 64'(almost_full), 64'd0);
      if (i == 13) chk("fill_af_at14", 64'(almost_full), 64'd1);
      if (i == 14) chk("fill_full_at15", 64'(full), 64'd0);
    end
    chk("fill_full", 64'(full), 64'd1);
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, '0, 1, 2'd0, 0);
      chk("drain_valid", 64'(rd_valid), 64'd1);
      chk("drain_data", rd_data, 64'(i));
    end
    chk("drain_empty", 64'(empty), 64'd1);
    idle(2'd0);

    // Overflow with a same-cycle read, then underflow, then clear.
    for (int i = 0; i < 16; i++) cycle(0, 1, 64'(32'h100 + i), 0, 2'd0, 0);
    cycle(0, 1, 64'hDEAD, 1, 2'd0, 0);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_count", 64'(count), 64'd15);
    chk("ovf_read", rd_data, 64'h100);
    for (int i = 0; i < 15; i++) cycle(0, 0, '0, 1, 2'd0, 0);
    chk("ovf_last_word", rd_data, 64'h10F);
    cycle(0, 0, '0, 1, 2'd0, 0);
    chk("udf_flag", 64'(underflow), 64'd1);
    cycle(0, 0, '0, 0, 2'd0, 1);
    chk("clr_overflow", 64'(overflow), 64'd0);
    chk("clr_underflow", 64'(underflow), 64'd0);

    // Pacing at 1G, then a mid-drain switch to 2.5G.
    for (int i = 0; i < 6; i++) cycle(0, 1, 64'(32'h200 + i), 0, 2'd3, 0);
    sw = -1;
    for (int t = 0; t < 200 && pulses.size() < 6; t++) begin
      if (sw < 0 && pulses.size() == 3 && t == pulses[2] + 3) sw = t;
      md = (sw >= 0) ? 2'd2 : 2'd3;
      cycle(0, 0, '0, 1, md, 0);
      if (rd_valid) pulses.push_back(t);
    end
    chk("pace_pulses", 64'(pulses.size()), 64'd6);
    if (pulses.size() == 6) begin
      chk("pace_1g_gap1", 64'(pulses[1] - pulses[0]), 64'd10);
      chk("pace_1g_gap2", 64'(pulses[2] - pulses[1]), 64'd10);
      chk("pace_switch", 64'(pulses[3] - sw), 64'd1);
      chk("pace_2p5_gap1", 64'(pulses[4] - pulses[3]), 64'd4);
      chk("pace_2p5_gap2", 64'(pulses[5] - pulses[4]), 64'd4);
    end
    idle(2'd0);

    // Simultaneous read/write at count 5 across pointer wrap.
    for (int i = 0; i < 5; i++) cycle(0, 1, 64'(32'h300 + i), 0, 2'd0, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, 64'(32'h305 + i), 1, 2'd0, 0);
      chk("rw_count", 64'(count), 64'd5);
      chk("rw_data", rd_data, 64'(32'h300 + i));
    end
    for (int i = 0; i < 5; i++) cycle(0, 0, '0, 1, 2'd0, 0);

    // Reset mid-stream at count 9.
    for (int i = 0; i < 9; i++) cycle(0, 1, 64'(32'h400 + i), 0, 2'd0, 0);
    chk("pre_reset_count", 64'(count), 64'd9);
    cycle(1, 0, '0, 1, 2'd0, 0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_valid", 64'(rd_valid), 64'd0);
    cycle(0, 1, 64'hA5, 0, 2'd0, 0);
    cycle(0, 0, '0, 1, 2'd0, 0);
    chk("rst_first_valid", 64'(rd_valid), 64'd1);
    chk("rst_first_data", rd_data, 64'hA5);

    // Randomized traffic against the model.
    md = 2'd0;
    for (int t = 0; t < 3000; t++) begin
      bit r, w, rr, ce;
      int wp;
      wp = ((t / 250) % 2 == 0) ? 75 : 30;
      r  = ($urandom_range(0, 299) == 0);
      w  = ($urandom_range(0, 99) < wp);
      rr = ($urandom_range(0, 99) < 60);
      ce = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 59) == 0) md = 2'($urandom_range(0, 3));
      cycle(r, w, {$urandom, $urandom}, rr, md, ce);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
